pss_uart_dma_engine: RTL

//  Shared easyDMA engine for NUM_CH UART channels in the peripheral subsystem.

---
 rtl/pss_uart_dma_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pss_uart_dma_engine.sv
// Shared UART easyDMA engine: NUM_CH RX/TX channels arbitrated round-robin onto one byte-wide RAM port.
// RX: grant -> RXWR (RAM write).  TX: grant -> TXRD (RAM read) -> TXWAIT (push to UART).
module pss_uart_dma_engine #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic                           ckPeri,
    input  logic                           arst,
    input  logic [NUM_CH-1:0]              taskStartRx,
    input  logic [NUM_CH-1:0]              taskStartTx,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  rxBase,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  txBase,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   rxMaxCnt,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   txMaxCnt,
    input  logic [NUM_CH-1:0]              rxDataReady,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  rxData,
    output logic [NUM_CH-1:0]              dmaRxReP,
    input  logic [NUM_CH-1:0]              txDataReady,
    output logic [NUM_CH-1:0]              dmaTxWeP,
    output logic [DATA_W-1:0]              txData,
    output logic                           ramSel,
    output logic                           ramWrite,
    output logic [ADDR_W-1:0]              ramAddr,
    output logic [DATA_W-1:0]              ramWData,
    input  logic [DATA_W-1:0]              ramRData,
    output logic [NUM_CH-1:0]              eventEndRx,
    output logic [NUM_CH-1:0]              eventTxCompleted,
    output logic [NUM_CH-1:0][CNT_W-1:0]   rxAmount,
    output logic [NUM_CH-1:0][CNT_W-1:0]   txAmount
);
    localparam int NREQ = 2 * NUM_CH;
    localparam int IW   = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RXWR, TXRD, TXWAIT} state_t;
    state_t r_state, w_stateNxt;

    logic [IW-1:0]                  r_rrPtr, r_grant, w_pick, w_ptrNxt;
    logic                           w_found;
    logic [NREQ-1:0]                w_req;
    logic [NUM_CH-1:0]              w_gRx, w_gTx;
    logic [NUM_CH-1:0]              r_rxAct, r_txAct;
    logic [NUM_CH-1:0][ADDR_W-1:0]  r_rxPtr, r_txPtr;
    logic [NUM_CH-1:0][CNT_W-1:0]   r_rxRem, r_txRem, r_rxAmt, r_txAmt;
    logic [NUM_CH-1:0]              r_rxRe, r_txWe, r_evRx, r_evTx;
    logic                           r_ramSel, r_ramWrite;
    logic [ADDR_W-1:0]              r_ramAddr;
    logic [DATA_W-1:0]              r_ramWData;
    // A TX start landing on the in-flight read is parked here until the push completes.
    logic                           r_pendVld;
    logic [ADDR_W-1:0]              r_pendBase;
    logic [CNT_W-1:0]               r_pendCnt;

    // Channels being (re)started this cycle are masked so a grant never uses a stale pointer.
    always_comb begin
        w_req = '0;
        w_gRx = '0;
        w_gTx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_req[2*c]   = r_rxAct[c] & rxDataReady[c] & ~taskStartRx[c];
            w_req[2*c+1] = r_txAct[c] & txDataReady[c] & ~taskStartTx[c];
            w_gRx[c]     = (r_grant == IW'(2*c));
            w_gTx[c]     = (r_grant == IW'(2*c+1));
        end
    end

    // Lowest requester at/after the pointer, else lowest overall (cyclic wrap).
    always_comb begin
        w_found = |w_req;
        w_pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_req[k]) w_pick = IW'(k);
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_req[k] && (IW'(k) >= r_rrPtr)) w_pick = IW'(k);
        w_ptrNxt = (w_pick == IW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
    end

    always_comb begin
        w_stateNxt = IDLE;
        case (r_state)
            IDLE:    if (w_found) w_stateNxt = w_pick[0] ? TXRD : RXWR;
            TXRD:    w_stateNxt = TXWAIT;
            default: w_stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge ckPeri) begin
        if (arst) r_state <= IDLE;
        else      r_state <= w_stateNxt;
    end

    always_ff @(posedge ckPeri) begin
        if (arst) begin
            r_rrPtr    <= '0;
            r_grant    <= '0;
            r_rxAct    <= '0;
            r_txAct    <= '0;
            r_rxPtr    <= '0;
            r_txPtr    <= '0;
            r_rxRem    <= '0;
            r_txRem    <= '0;
            r_rxAmt    <= '0;
            r_txAmt    <= '0;
            r_rxRe     <= '0;
            r_txWe     <= '0;
            r_evRx     <= '0;
            r_evTx     <= '0;
            r_ramSel   <= 1'b0;
            r_ramWrite <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWData <= '0;
            r_pendVld  <= 1'b0;
            r_pendBase <= '0;
            r_pendCnt  <= '0;
        end else begin
            r_rxRe     <= '0;
            r_txWe     <= '0;
            r_evRx     <= '0;
            r_evTx     <= '0;
            r_ramSel   <= 1'b0;
            r_ramWrite <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWData <= '0;

            // Bus outputs for the next state are registered at grant time.
            if (r_state == IDLE && w_found) begin
                r_grant    <= w_pick;
                r_rrPtr    <= w_ptrNxt;
                r_ramSel   <= 1'b1;
                r_ramWrite <= ~w_pick[0];
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_pick == IW'(2*c)) begin
                        r_rxRe[c]  <= 1'b1;
                        r_ramAddr  <= r_rxPtr[c];
                        r_ramWData <= rxData[c];
                    end
                    if (w_pick == IW'(2*c+1)) r_ramAddr <= r_txPtr[c];
                end
            end

            if (r_state == TXWAIT) r_pendVld <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_state == TXRD && w_gTx[c]) begin
                    r_txWe[c] <= 1'b1;
                    if (taskStartTx[c]) begin
                        r_pendVld  <= 1'b1;
                        r_pendBase <= txBase[c];
                        r_pendCnt  <= txMaxCnt[c];
                    end
                end
            end

            for (int c = 0; c < NUM_CH; c++) begin
                // A start during RXWR replaces the pointer update; the write already went to the old address.
                if (taskStartRx[c]) begin
                    r_rxPtr[c] <= rxBase[c];
                    r_rxRem[c] <= rxMaxCnt[c];
                    r_rxAmt[c] <= '0;
                    r_rxAct[c] <= (rxMaxCnt[c] != '0);
                    r_evRx[c]  <= (rxMaxCnt[c] == '0);
                end else if (r_state == RXWR && w_gRx[c]) begin
                    r_rxPtr[c] <= r_rxPtr[c] + 1'b1;
                    r_rxAmt[c] <= r_rxAmt[c] + 1'b1;
                    if (r_rxRem[c] != '0) r_rxRem[c] <= r_rxRem[c] - 1'b1;
                    if (r_rxRem[c] <= CNT_W'(1)) begin
                        r_rxAct[c] <= 1'b0;
                        r_evRx[c]  <= 1'b1;
                    end
                end

                if (taskStartTx[c] && !(r_state == TXRD && w_gTx[c])) begin
                    r_txPtr[c] <= txBase[c];
                    r_txRem[c] <= txMaxCnt[c];
                    r_txAmt[c] <= '0;
                    r_txAct[c] <= (txMaxCnt[c] != '0);
                    r_evTx[c]  <= (txMaxCnt[c] == '0);
                end else if (r_state == TXWAIT && w_gTx[c] && r_pendVld) begin
                    r_txPtr[c] <= r_pendBase;
                    r_txRem[c] <= r_pendCnt;
                    r_txAmt[c] <= '0;
                    r_txAct[c] <= (r_pendCnt != '0);
                    r_evTx[c]  <= (r_pendCnt == '0);
                end else if (r_state == TXWAIT && w_gTx[c]) begin
                    r_txPtr[c] <= r_txPtr[c] + 1'b1;
                    r_txAmt[c] <= r_txAmt[c] + 1'b1;
                    if (r_txRem[c] != '0) r_txRem[c] <= r_txRem[c] - 1'b1;
                    if (r_txRem[c] <= CNT_W'(1)) begin
                        r_txAct[c] <= 1'b0;
                        r_evTx[c]  <= 1'b1;
                    end
                end
            end
        end
    end

    assign dmaRxReP         = r_rxRe;
    assign dmaTxWeP         = r_txWe;
    assign txData           = (|r_txWe) ? ramRData : '0;
    assign ramSel           = r_ramSel;
    assign ramWrite         = r_ramWrite;
    assign ramAddr          = r_ramAddr;
    assign ramWData         = r_ramWData;
    assign eventEndRx       = r_evRx;
    assign eventTxCompleted = r_evTx;
    assign rxAmount         = r_rxAmt;
    assign txAmount         = r_txAmt;
endmodule
